// File: rtl/down_counter_if.sv
// down_counter_if: load handshake, control and status bundle for down_counter.
interface down_counter_if #(parameter int WIDTH = 8);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] dout;
   logic             busy;
   logic             done;
   modport master (output load_valid, load_value, en, abort, input load_ready, dout, busy, done);
   modport slave  (input load_valid, load_value, en, abort, output load_ready, dout, busy, done);
endinterface

// File: rtl/down_counter.sv
// down_counter: loadable down-counting timer with valid/ready load and a one-cycle done pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
module down_counter #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   down_counter_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic done_q, done_nx;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) reload_q <= '0;
      else if (state == IDLE && bus.load_valid) reload_q <= bus.load_value;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         done_q <= done_nx;
      end
   // abort outranks expiry, expiry outranks a plain decrement
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      if (state == IDLE) begin
         if (bus.load_valid) begin
            cnt_nx   = bus.load_value;
            state_nx = (bus.load_value == '0) ? IDLE : RUN;
            done_nx  = (bus.load_value == '0);
         end
      end else if (bus.abort) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (bus.en) begin
         if (cnt == WIDTH'(1)) begin
            done_nx = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            cnt_nx  = reload_q;
`else
            cnt_nx   = '0;
            state_nx = IDLE;
`endif
         end else cnt_nx = cnt - WIDTH'(1);
      end
   end
   assign bus.load_ready = (state == IDLE);
   assign bus.busy       = (state == RUN);
   assign bus.dout       = cnt;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed scoreboard bench; stimulus queues expected outputs, a negedge monitor checks them.
module tb_down_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int failed = 0;
   int cyc = 0;
   typedef struct packed {int id; logic [7:0] d; logic b; logic dn; logic r;} exp_t;
   exp_t q[$];
   down_counter_if #(.WIDTH(8)) bus();
   down_counter #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s step%0d: got %0h expected %0h", name, id, act, exp);
      end
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("dout", e.id, bus.dout, e.d);
         chk("busy", e.id, 8'(bus.busy), 8'(e.b));
         chk("done", e.id, 8'(bus.done), 8'(e.dn));
         chk("load_ready", e.id, 8'(bus.load_ready), 8'(e.r));
      end
   task automatic step(input logic lv, input logic [7:0] val, input logic e, input logic ab,
                       input logic [7:0] xd, input logic xb, input logic xdn, input logic xr);
      @(negedge clk);
      #1;
      bus.load_valid = lv;
      bus.load_value = val;
      bus.en = e;
      bus.abort = ab;
      @(posedge clk);
      cyc++;
      q.push_back('{cyc, xd, xb, xdn, xr});
   endtask
   task automatic idle_chk(input string name);
      chk({name, "_dout"}, cyc, bus.dout, 8'h00);
      chk({name, "_busy"}, cyc, 8'(bus.busy), 8'h0);
      chk({name, "_done"}, cyc, 8'(bus.done), 8'h0);
      chk({name, "_ready"}, cyc, 8'(bus.load_ready), 8'h1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.load_valid = 1'b0;
      bus.load_value = '0;
      bus.en = 1'b0;
      bus.abort = 1'b0;
      #2 idle_chk("por");
      #10 rst = 1'b0;
      // mid-count async reset at 0x23
      step(1, 8'h23, 0, 0, 8'h23, 1, 0, 0);
      step(0, 8'h00, 0, 0, 8'h23, 1, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 idle_chk("async_rst");
      @(negedge clk);
      rst = 1'b0;
      // zero-length load
      step(1, 8'h00, 1, 0, 8'h00, 0, 1, 1);
      step(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      step(1, 8'h04, 1, 0, 8'h04, 1, 0, 0);
      for (int k = 0; k < 12; k++)
         step(1, 8'h09, 1, 0, 8'(3 - (k % 4) + ((k % 4) == 3 ? 4 : 0)), 1, (k % 4) == 3, 0);
      step(0, 8'h00, 1, 1, 8'h00, 0, 0, 1);
      step(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
`else
      // one-shot 5
      step(1, 8'h05, 1, 0, 8'h05, 1, 0, 0);
      for (int k = 4; k >= 1; k--) step(0, 8'h00, 1, 0, 8'(k), 1, 0, 0);
      step(0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
      step(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
      // enable gating
      step(1, 8'h03, 0, 0, 8'h03, 1, 0, 0);
      step(0, 8'h00, 1, 0, 8'h02, 1, 0, 0);
      step(0, 8'h00, 0, 0, 8'h02, 1, 0, 0);
      step(0, 8'h00, 0, 0, 8'h02, 1, 0, 0);
      step(0, 8'h00, 1, 0, 8'h01, 1, 0, 0);
      step(0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
      // abort at dout=1 wins over expiry
      step(1, 8'h0a, 1, 0, 8'h0a, 1, 0, 0);
      for (int k = 9; k >= 1; k--) step(0, 8'h00, 1, 0, 8'(k), 1, 0, 0);
      step(0, 8'h00, 1, 1, 8'h00, 0, 0, 1);
      step(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
      // load_valid ignored while running
      step(1, 8'h03, 1, 0, 8'h03, 1, 0, 0);
      step(1, 8'h07, 1, 0, 8'h02, 1, 0, 0);
      step(1, 8'h07, 1, 0, 8'h01, 1, 0, 0);
      step(0, 8'h07, 1, 0, 8'h00, 0, 1, 1);
      // back-to-back loads of 2
      for (int k = 0; k < 3; k++) begin
         step(1, 8'h02, 1, 0, 8'h02, 1, 0, 0);
         step(1, 8'h02, 1, 0, 8'h01, 1, 0, 0);
         step(1, 8'h02, 1, 0, 8'h00, 0, 1, 1);
      end
      step(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
      // minimum count of 1
      step(1, 8'h01, 1, 0, 8'h01, 1, 0, 0);
      step(0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
      // abort in IDLE does not block a load
      step(1, 8'h04, 0, 1, 8'h04, 1, 0, 0);
      step(0, 8'h00, 0, 1, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
`endif
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         tests++;
         failed++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
